// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory request front-end.
// Optional feature macro used by mem_req_arb: MEM_UNSWAP_EN.
package mem_pkg;

   // Response FSM: IDLE = no read response pending, RSP = response pending
   typedef enum logic {
      IDLE = 1'b0,
      RSP  = 1'b1
   } arb_state_e;

   // Swaps the two halves of a w-bit word held in the low bits of data.
   // Used by the memory write path for upper addresses and by the unswap option.
   // Supports words up to 64 bits; w must be even.
   function automatic logic [63:0] half_swap(input logic [63:0] data, input int w);
      logic [63:0] res;
      res = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < w) begin
            res[6'(i)] = data[6'((i + w / 2) % w)];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_req_arb_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
// req[0]/gnt[0] is the write side, req[1]/gnt[1] the read side.
// prio=0 favours requester 0 on contention, prio=1 favours requester 1.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic prio_q;
   logic prio_d;

   // Grant selection; prio only moves when both requesters compete
   always_comb begin
      gnt    = req;
      prio_d = prio_q;
      if (req == 2'b11) begin
         gnt    = prio_q ? 2'b10 : 2'b01;
         prio_d = ~prio_q;
      end
   end

   // Priority register
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/mem_req_arb.sv
// mem_req_arb: write/read request front-end for the single-port-pair memory.
// At most one memory op per cycle; read data returned on a valid/ready channel.
// Optional MEM_UNSWAP_EN: undo the memory's half swap for upper-half reads so
// the requester reads back exactly what it wrote.
module mem_req_arb
   import mem_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int PSIZE = 2,
   parameter int DEPTH = 2 ** PSIZE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [PSIZE-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_valid,
   output logic             rd_ready,
   input  logic [PSIZE-1:0] rd_addr,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             mem_wr,
   output logic             mem_rd,
   output logic [PSIZE-1:0] mem_wr_addr,
   output logic [PSIZE-1:0] mem_rd_addr,
   output logic [WIDTH-1:0] mem_wr_data,
   input  logic [WIDTH-1:0] mem_rd_data
);

   arb_state_e state_q;
   arb_state_e state_d;
   logic       rd_el;
   logic       wr_el;
   logic [1:0] req;
   logic [1:0] gnt;

   // A read may only issue when no response is pending or the pending one leaves now
   assign rd_el = rd_valid && ((state_q == IDLE) || rsp_ready);
   assign wr_el = wr_valid;
   assign req   = {rd_el, wr_el} & {2{~rst}};

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a read grant always leaves a response pending
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (gnt[1]) state_d = RSP;
         RSP:  if (!gnt[1] && rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef MEM_UNSWAP_EN
   localparam logic [PSIZE-1:0] HALF_ADDR = PSIZE'(DEPTH / 2);

   logic upper_q;
   logic upper_d;

   // Remember whether the outstanding read targets the swapped upper half
   always_comb begin
      upper_d = upper_q;
      if (gnt[1]) upper_d = (rd_addr >= HALF_ADDR);
   end

   // Upper-half flag register
   always_ff @(posedge clk) begin
      if (rst) begin
         upper_q <= 1'b0;
      end else begin
         upper_q <= upper_d;
      end
   end
`endif

   // Outputs: handshakes follow the grant, memory ports are pass-through
   always_comb begin
      wr_ready    = gnt[0];
      mem_wr      = gnt[0];
      rd_ready    = gnt[1];
      mem_rd      = gnt[1];
      mem_wr_addr = wr_addr;
      mem_rd_addr = rd_addr;
      mem_wr_data = wr_data;
      rsp_valid   = (state_q == RSP) && !rst;
`ifdef MEM_UNSWAP_EN
      rsp_data    = upper_q ? WIDTH'(half_swap(64'(mem_rd_data), WIDTH)) : mem_rd_data;
`else
      rsp_data    = mem_rd_data;
`endif
   end

endmodule

// File: tb/tb_mem_req_arb.sv
// Self-checking bench for mem_req_arb with a behavioural memory and a
// transaction-level reference model (logical contents, pending response, priority).
module tb_mem_req_arb;
   import mem_pkg::*;

   localparam int WIDTH = 2;
   localparam int PSIZE = 2;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_valid, wr_ready;
   logic [PSIZE-1:0] wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             rd_valid, rd_ready;
   logic [PSIZE-1:0] rd_addr;
   logic             rsp_valid, rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             mem_wr, mem_rd;
   logic [PSIZE-1:0] mem_wr_addr, mem_rd_addr;
   logic [WIDTH-1:0] mem_wr_data;
   logic [WIDTH-1:0] mem_rd_data;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   mem_req_arb #(.WIDTH(WIDTH), .PSIZE(PSIZE), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_addr     (rd_addr),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .mem_wr      (mem_wr),
      .mem_rd      (mem_rd),
      .mem_wr_addr (mem_wr_addr),
      .mem_rd_addr (mem_rd_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data)
   );

   // Memory: swaps halves on writes to the upper half, registered read data held while idle
   logic [WIDTH-1:0] mem_arr [DEPTH];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_arr[i] <= '0;
         mem_rd_data <= '0;
      end else begin
         if (mem_wr)
            mem_arr[mem_wr_addr] <= (int'(mem_wr_addr) >= DEPTH / 2) ?
                                    WIDTH'(half_swap(64'(mem_wr_data), WIDTH)) : mem_wr_data;
         if (mem_rd) mem_rd_data <= mem_arr[mem_rd_addr];
      end
   end

   // Reference model state
   logic [WIDTH-1:0] m_shadow [DEPTH];
   logic             m_pend = 1'b0;
   logic [WIDTH-1:0] m_held = '0;
   logic             m_prio = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // Value the requester should see for a read of address a
   function automatic logic [WIDTH-1:0] expect_read(input logic [PSIZE-1:0] a);
`ifdef MEM_UNSWAP_EN
      return m_shadow[a];
`else
      if (int'(a) >= DEPTH / 2) return WIDTH'(half_swap(64'(m_shadow[a]), WIDTH));
      return m_shadow[a];
`endif
   endfunction

   // One clock cycle: drive inputs, compare against model, advance model
   task automatic step(input logic r, input logic wv, input logic rv, input logic rr,
                       input logic [PSIZE-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic [PSIZE-1:0] ra);
      logic wel, rel, e_wg, e_rg;
      @(negedge clk);
      cyc++;
      rst = r; wr_valid = wv; rd_valid = rv; rsp_ready = rr;
      wr_addr = wa; wr_data = wd; rd_addr = ra;
      #2;
      wel = wv && !r;
      rel = rv && !r && (!m_pend || rr);
      if (wel && rel) begin
         e_wg = !m_prio;
         e_rg = m_prio;
      end else begin
         e_wg = wel;
         e_rg = rel;
      end
      check("wr_ready", 32'(wr_ready), 32'(e_wg));
      check("mem_wr", 32'(mem_wr), 32'(e_wg));
      check("rd_ready", 32'(rd_ready), 32'(e_rg));
      check("mem_rd", 32'(mem_rd), 32'(e_rg));
      check("one_op", 32'(mem_wr && mem_rd), 32'(0));
      check("rsp_valid", 32'(rsp_valid), 32'(m_pend && !r));
      if (m_pend && !r) check("rsp_data", 32'(rsp_data), 32'(m_held));
      if (e_wg) begin
         check("mem_wr_addr", 32'(mem_wr_addr), 32'(wa));
         check("mem_wr_data", 32'(mem_wr_data), 32'(wd));
      end
      if (e_rg) check("mem_rd_addr", 32'(mem_rd_addr), 32'(ra));
      if (r || e_wg || e_rg || (m_pend && rr))
         $display("cyc %0d rst=%0b wr=%0b(a%0d d%0h) rd=%0b(a%0d) rsp=%0b d%0h",
                  cyc, r, e_wg, wa, wd, e_rg, ra, m_pend && rr && !r, rsp_data);
      if (r) begin
         m_pend = 1'b0;
         m_prio = 1'b0;
         for (int i = 0; i < DEPTH; i++) m_shadow[i] = '0;
      end else begin
         if (wel && rel) m_prio = !m_prio;
         if (e_rg) begin
            m_pend = 1'b1;
            m_held = expect_read(ra);
         end else if (m_pend && rr) begin
            m_pend = 1'b0;
         end
         if (e_wg) m_shadow[wa] = wd;
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_shadow[i] = '0;
      rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
      wr_addr = '0; wr_data = '0; rd_addr = '0;

      // Reset with both requests held high
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 2'd0);
         check("t1_rsp_valid", 32'(rsp_valid), 32'(0));
      end

      // Write then read a lower-half address
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'b10, 2'd0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'b00, 2'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'd0);
      check("t2_rsp_valid", 32'(rsp_valid), 32'(1));
      check("t2_rsp_data", 32'(rsp_data), 32'(2'b10));
      step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'b00, 2'd0);

      // Write then read an upper-half address
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 2'b01, 2'd0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'b00, 2'd3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'd0);
`ifdef MEM_UNSWAP_EN
      check("t3_rsp_data", 32'(rsp_data), 32'(2'b01));
`else
      check("t3_rsp_data", 32'(rsp_data), 32'(2'b10));
`endif
      step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'b00, 2'd0);

      // Contention: grants alternate starting with write after reset
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'd0);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1, PSIZE'($urandom_range(0, 3)),
              WIDTH'($urandom_range(0, 3)), PSIZE'($urandom_range(0, 3)));
         check("t4_alt_wr", 32'(mem_wr), 32'(k % 2 == 0));
         check("t4_alt_rd", 32'(mem_rd), 32'(k % 2 == 1));
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'b00, 2'd0);

      // Backpressured response while writes continue
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'b00, 2'd2);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, WIDTH'(k), 2'd1);
         check("t5_wr_ready", 32'(wr_ready), 32'(1));
         check("t5_rd_ready", 32'(rd_ready), 32'(0));
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'b00, 2'd0);

      // Reset while a response is pending
      step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'b11, 2'd0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'b00, 2'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'd0);
      check("t6_pending", 32'(rsp_valid), 32'(1));
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'd0);
      check("t6_dropped", 32'(rsp_valid), 32'(0));
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'b00, 2'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'b00, 2'd0);
      check("t6_first_read", 32'(rsp_data), 32'(2'b00));
      step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'b00, 2'd0);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
              PSIZE'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 3)),
              PSIZE'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
